elastic_pipe_m: RTL



---
 rtl/elastic_pipe_m.sv | 85 ++++++++
 1 files changed

// File: rtl/elastic_pipe_m.sv
// Elastic DEPTH-stage register pipeline with valid/ready handshake on both ends,
// bubble collapsing, global hold (enb), synchronous flush and occupancy count.
module elastic_pipe_m #(
    parameter int W     = 8,
    parameter int DEPTH = 3,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enb,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  d,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  q,
    output logic [CW-1:0] count
);

    logic [DEPTH-1:0] v_r;
    logic [W-1:0]     data_r     [DEPTH];
    logic [DEPTH-1:0] rdy_s;
    logic             chain_s;
    logic [DEPTH-1:0] v_src_s;
    logic [W-1:0]     data_src_s [DEPTH];
    logic             run_s;

    function automatic logic [CW-1:0] popcount(input logic [DEPTH-1:0] v);
        logic [CW-1:0] n;
        n = {CW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            n = n + CW'(v[i]);
        end
        return n;
    endfunction

    // Ready chain: a stage may advance if it, or any stage after it, is empty, or the sink is ready.
    always_comb begin
        rdy_s   = {DEPTH{1'b0}};
        chain_s = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            chain_s  = chain_s | ~v_r[i];
            rdy_s[i] = chain_s;
        end
    end

    // Stage sources: stage 0 takes the input port, stage i takes stage i-1.
    always_comb begin
        v_src_s       = {DEPTH{1'b0}};
        v_src_s[0]    = in_valid;
        data_src_s[0] = d;
        for (int i = 1; i < DEPTH; i++) begin
            v_src_s[i]    = v_r[i-1];
            data_src_s[i] = data_r[i-1];
        end
    end

    // Handshakes are masked while held or flushing; count always shows the real occupancy.
    assign run_s     = enb & ~flush;
    assign in_ready  = run_s & rdy_s[0];
    assign out_valid = run_s & v_r[DEPTH-1];
    assign q         = data_r[DEPTH-1];
    assign count     = popcount(v_r);

    // Stage registers: flush clears valids only, hold freezes everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_r <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i] <= {W{1'b0}};
            end
        end else if (flush) begin
            v_r <= {DEPTH{1'b0}};
        end else if (enb) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rdy_s[i]) begin
                    v_r[i]    <= v_src_s[i];
                    data_r[i] <= data_src_s[i];
                end
            end
        end
    end

endmodule
